// File: rtl/rename_regfile_pkg.sv
// ---------------------------------------------------------------------------
// rename_regfile_pkg
// Shared types and default sizes for the rename register file.
//   nzcv_t            : 4-bit condition flags {N, Z, C, V}
//   rename_entry_t    : one register's rename record {value, pending, tag}
//                       at the default widths
//   *_DEFAULT         : default parameter values used by rename_regfile
// ---------------------------------------------------------------------------
package rename_regfile_pkg;

   localparam int GPR_COUNT_DEFAULT = 32;
   localparam int ROB_IDX_W_DEFAULT = 4;
   localparam int DATA_W_DEFAULT    = 64;

   typedef logic [3:0] nzcv_t;

   typedef struct packed {
      logic [DATA_W_DEFAULT-1:0]    value;
      logic                         pending;
      logic [ROB_IDX_W_DEFAULT-1:0] tag;
   } rename_entry_t;

endpackage

// File: rtl/rename_operand_resolve.sv
// ---------------------------------------------------------------------------
// rename_operand_resolve
// Resolves one source operand at dispatch time. Priority, highest first:
//   immediate -> hard-wired zero -> architectural (not pending)
//   -> same-cycle commit bypass (tag match, highest port wins) -> wait on tag.
// Ports:
//   in_use_imm, in_imm     : immediate select and value
//   in_is_zero             : operand is the zero register
//   in_pending, in_arch_value, in_reg_tag : rename state of the source
//   in_c_en, in_c_tag, in_c_value         : flattened commit ports
//   out_valid, out_tag, out_value         : resolved operand (tag 0 if valid)
// ---------------------------------------------------------------------------
module rename_operand_resolve
   import rename_regfile_pkg::*;
#(
   parameter int W     = 64,
   parameter int TW    = 4,
   parameter int PORTS = 2
) (
   input  logic              in_use_imm,
   input  logic [W-1:0]      in_imm,
   input  logic              in_is_zero,
   input  logic              in_pending,
   input  logic [W-1:0]      in_arch_value,
   input  logic [TW-1:0]     in_reg_tag,
   input  logic [PORTS-1:0]  in_c_en,
   input  logic [PORTS*TW-1:0] in_c_tag,
   input  logic [PORTS*W-1:0]  in_c_value,
   output logic              out_valid,
   output logic [TW-1:0]     out_tag,
   output logic [W-1:0]      out_value
);

   logic         w_hit;
   logic [W-1:0] w_hit_value;

   // Ascending scan so the highest-index (youngest) matching port wins.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_value = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (in_c_en[p] && (in_c_tag[p*TW +: TW] == in_reg_tag)) begin
            w_hit       = 1'b1;
            w_hit_value = in_c_value[p*W +: W];
         end
      end
   end

   always_comb begin
      out_valid = 1'b1;
      out_tag   = '0;
      out_value = '0;
      if (in_use_imm) begin
         out_value = in_imm;
      end else if (in_is_zero) begin
         out_value = '0;
      end else if (!in_pending) begin
         out_value = in_arch_value;
      end else if (w_hit) begin
         out_value = w_hit_value;
      end else begin
         out_valid = 1'b0;
         out_tag   = in_reg_tag;
      end
   end

endmodule

// File: rtl/rename_regfile.sv
// ---------------------------------------------------------------------------
// rename_regfile
// Architectural GPR + NZCV storage with per-register rename state. Each
// accepted dispatch resolves src1/src2/NZCV and renames its destination; the
// resolved bundle is registered into a one-entry valid/ready output stage.
// Ports:
//   in_clk, in_rst_n                 : clock, async active-low reset
//   in_d_* / out_d_ready             : dispatch request and handshake
//   in_rob_next_index                : ROB tag given to this dispatch
//   in_c_*                           : COMMIT_PORTS commit ports (flattened)
//   in_flush                         : drop all pending state and the stage
//   out_valid / in_ready             : output stage handshake
//   out_src*/out_nzcv*/out_dst*      : resolved operand bundle
// ---------------------------------------------------------------------------
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int GPR_COUNT    = GPR_COUNT_DEFAULT,
   parameter int DATA_W       = DATA_W_DEFAULT,
   parameter int ROB_IDX_W    = ROB_IDX_W_DEFAULT,
   parameter int COMMIT_PORTS = 2,
   parameter int ZERO_REG     = 31,
   localparam int IDX_W       = $clog2(GPR_COUNT)
) (
   input  logic                           in_clk,
   input  logic                           in_rst_n,
   input  logic                           in_d_valid,
   output logic                           out_d_ready,
   input  logic [IDX_W-1:0]               in_d_src1,
   input  logic [IDX_W-1:0]               in_d_src2,
   input  logic [IDX_W-1:0]               in_d_dst,
   input  logic                           in_d_dst_we,
   input  logic                           in_d_set_nzcv,
   input  logic                           in_d_uses_nzcv,
   input  logic                           in_d_use_imm,
   input  logic [DATA_W-1:0]              in_d_imm,
   input  logic [ROB_IDX_W-1:0]           in_rob_next_index,
   input  logic [COMMIT_PORTS-1:0]        in_c_valid,
   input  logic [COMMIT_PORTS*IDX_W-1:0]  in_c_reg,
   input  logic [COMMIT_PORTS*ROB_IDX_W-1:0] in_c_tag,
   input  logic [COMMIT_PORTS*DATA_W-1:0] in_c_value,
   input  logic [COMMIT_PORTS-1:0]        in_c_set_nzcv,
   input  logic [COMMIT_PORTS*4-1:0]      in_c_nzcv,
   input  logic                           in_flush,
   output logic                           out_valid,
   input  logic                           in_ready,
   output logic                           out_src1_valid,
   output logic                           out_src2_valid,
   output logic                           out_nzcv_valid,
   output logic [ROB_IDX_W-1:0]           out_src1_tag,
   output logic [ROB_IDX_W-1:0]           out_src2_tag,
   output logic [ROB_IDX_W-1:0]           out_nzcv_tag,
   output logic [DATA_W-1:0]              out_src1_value,
   output logic [DATA_W-1:0]              out_src2_value,
   output nzcv_t                          out_nzcv,
   output logic [IDX_W-1:0]               out_dst,
   output logic [ROB_IDX_W-1:0]           out_dst_tag,
   output logic                           out_set_nzcv,
   output logic                           out_uses_nzcv
);

   localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high. The dispatch side (in_d_valid/out_d_ready) may only be
   // accepted when the output stage is empty or draining this cycle and no
   // flush is active; out_valid, once high, holds the bundle until in_ready.

   // ---------------- storage ----------------
   logic [DATA_W-1:0]    r_value [GPR_COUNT];
   logic [GPR_COUNT-1:0] r_pending;
   logic [ROB_IDX_W-1:0] r_tag   [GPR_COUNT];
   nzcv_t                r_nzcv;
   logic                 r_nzcv_pending;
   logic [ROB_IDX_W-1:0] r_nzcv_tag;

   // ---------------- output stage ----------------
   logic                 r_out_valid;
   logic                 r_src1_valid, r_src2_valid, r_onzcv_valid;
   logic [ROB_IDX_W-1:0] r_src1_tag, r_src2_tag, r_onzcv_tag;
   logic [DATA_W-1:0]    r_src1_value, r_src2_value;
   nzcv_t                r_onzcv;
   logic [IDX_W-1:0]     r_out_dst;
   logic [ROB_IDX_W-1:0] r_out_dst_tag;
   logic                 r_out_set_nzcv, r_out_uses_nzcv;

   logic w_load, w_accept, w_rename;
   logic [COMMIT_PORTS-1:0] w_c_nzcv_en;

   assign w_load      = !r_out_valid || in_ready;
   assign out_d_ready = !in_flush && w_load;
   assign w_accept    = in_d_valid && out_d_ready;
   assign w_rename    = w_accept && in_d_dst_we && (in_d_dst != ZERO_IDX);
   assign w_c_nzcv_en = in_c_valid & in_c_set_nzcv;

   // ---------------- operand resolution ----------------
   logic                 w_src1_valid, w_src2_valid, w_nzcv_valid;
   logic [ROB_IDX_W-1:0] w_src1_tag, w_src2_tag, w_nzcv_tag;
   logic [DATA_W-1:0]    w_src1_value, w_src2_value;
   nzcv_t                w_nzcv_value;

   rename_operand_resolve #(.W(DATA_W), .TW(ROB_IDX_W), .PORTS(COMMIT_PORTS)) u_src1 (
      .in_use_imm(1'b0), .in_imm('0), .in_is_zero(in_d_src1 == ZERO_IDX),
      .in_pending(r_pending[in_d_src1]), .in_arch_value(r_value[in_d_src1]),
      .in_reg_tag(r_tag[in_d_src1]), .in_c_en(in_c_valid), .in_c_tag(in_c_tag),
      .in_c_value(in_c_value), .out_valid(w_src1_valid), .out_tag(w_src1_tag),
      .out_value(w_src1_value)
   );

   rename_operand_resolve #(.W(DATA_W), .TW(ROB_IDX_W), .PORTS(COMMIT_PORTS)) u_src2 (
      .in_use_imm(in_d_use_imm), .in_imm(in_d_imm), .in_is_zero(in_d_src2 == ZERO_IDX),
      .in_pending(r_pending[in_d_src2]), .in_arch_value(r_value[in_d_src2]),
      .in_reg_tag(r_tag[in_d_src2]), .in_c_en(in_c_valid), .in_c_tag(in_c_tag),
      .in_c_value(in_c_value), .out_valid(w_src2_valid), .out_tag(w_src2_tag),
      .out_value(w_src2_value)
   );

   rename_operand_resolve #(.W(4), .TW(ROB_IDX_W), .PORTS(COMMIT_PORTS)) u_nzcv (
      .in_use_imm(1'b0), .in_imm(4'h0), .in_is_zero(1'b0),
      .in_pending(r_nzcv_pending), .in_arch_value(r_nzcv),
      .in_reg_tag(r_nzcv_tag), .in_c_en(w_c_nzcv_en), .in_c_tag(in_c_tag),
      .in_c_value(in_c_nzcv), .out_valid(w_nzcv_valid), .out_tag(w_nzcv_tag),
      .out_value(w_nzcv_value)
   );

   // ---------------- commit decode ----------------
   logic [GPR_COUNT-1:0] w_wr_en, w_clear;
   logic [DATA_W-1:0]    w_wr_value [GPR_COUNT];
   logic                 w_nzcv_wr, w_nzcv_clear;
   nzcv_t                w_nzcv_wr_value;

   always_comb begin
      w_wr_en         = '0;
      w_clear         = '0;
      w_nzcv_wr       = 1'b0;
      w_nzcv_clear    = 1'b0;
      w_nzcv_wr_value = r_nzcv;
      for (int i = 0; i < GPR_COUNT; i++) w_wr_value[i] = '0;
      for (int p = 0; p < COMMIT_PORTS; p++) begin
         if (in_c_valid[p] && (in_c_reg[p*IDX_W +: IDX_W] != ZERO_IDX)) begin
            w_wr_en[in_c_reg[p*IDX_W +: IDX_W]]    = 1'b1;
            w_wr_value[in_c_reg[p*IDX_W +: IDX_W]] = in_c_value[p*DATA_W +: DATA_W];
            // Only the producer the register currently waits on releases it.
            if (r_tag[in_c_reg[p*IDX_W +: IDX_W]] == in_c_tag[p*ROB_IDX_W +: ROB_IDX_W])
               w_clear[in_c_reg[p*IDX_W +: IDX_W]] = 1'b1;
         end
         if (w_c_nzcv_en[p]) begin
            w_nzcv_wr       = 1'b1;
            w_nzcv_wr_value = in_c_nzcv[p*4 +: 4];
            if (r_nzcv_tag == in_c_tag[p*ROB_IDX_W +: ROB_IDX_W]) w_nzcv_clear = 1'b1;
         end
      end
   end

   // A same-cycle rename takes priority over a pending clear.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         for (int i = 0; i < GPR_COUNT; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
         end
         r_pending      <= '0;
         r_nzcv         <= '0;
         r_nzcv_pending <= 1'b0;
         r_nzcv_tag     <= '0;
      end else begin
         for (int i = 0; i < GPR_COUNT; i++) begin
            if (w_wr_en[i]) r_value[i] <= w_wr_value[i];
            if (in_flush) begin
               r_pending[i] <= 1'b0;
            end else if (w_rename && (in_d_dst == IDX_W'(i))) begin
               r_pending[i] <= 1'b1;
               r_tag[i]     <= in_rob_next_index;
            end else if (w_clear[i]) begin
               r_pending[i] <= 1'b0;
            end
         end
         if (w_nzcv_wr) r_nzcv <= w_nzcv_wr_value;
         if (in_flush) begin
            r_nzcv_pending <= 1'b0;
         end else if (w_accept && in_d_set_nzcv) begin
            r_nzcv_pending <= 1'b1;
            r_nzcv_tag     <= in_rob_next_index;
         end else if (w_nzcv_clear) begin
            r_nzcv_pending <= 1'b0;
         end
      end
   end

   // ---------------- wake-up of a stalled bundle ----------------
   logic                 w_wk1_hit, w_wk2_hit, w_wkn_hit;
   logic [DATA_W-1:0]    w_wk1_value, w_wk2_value;
   nzcv_t                w_wkn_value;

   always_comb begin
      w_wk1_hit   = 1'b0;
      w_wk2_hit   = 1'b0;
      w_wkn_hit   = 1'b0;
      w_wk1_value = '0;
      w_wk2_value = '0;
      w_wkn_value = '0;
      for (int p = 0; p < COMMIT_PORTS; p++) begin
         if (in_c_valid[p] && (in_c_tag[p*ROB_IDX_W +: ROB_IDX_W] == r_src1_tag)) begin
            w_wk1_hit   = 1'b1;
            w_wk1_value = in_c_value[p*DATA_W +: DATA_W];
         end
         if (in_c_valid[p] && (in_c_tag[p*ROB_IDX_W +: ROB_IDX_W] == r_src2_tag)) begin
            w_wk2_hit   = 1'b1;
            w_wk2_value = in_c_value[p*DATA_W +: DATA_W];
         end
         if (w_c_nzcv_en[p] && (in_c_tag[p*ROB_IDX_W +: ROB_IDX_W] == r_onzcv_tag)) begin
            w_wkn_hit   = 1'b1;
            w_wkn_value = in_c_nzcv[p*4 +: 4];
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         r_out_valid     <= 1'b0;
         r_src1_valid    <= 1'b0;
         r_src2_valid    <= 1'b0;
         r_onzcv_valid   <= 1'b0;
         r_src1_tag      <= '0;
         r_src2_tag      <= '0;
         r_onzcv_tag     <= '0;
         r_src1_value    <= '0;
         r_src2_value    <= '0;
         r_onzcv         <= '0;
         r_out_dst       <= '0;
         r_out_dst_tag   <= '0;
         r_out_set_nzcv  <= 1'b0;
         r_out_uses_nzcv <= 1'b0;
      end else if (in_flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_src1_valid    <= w_src1_valid;
            r_src2_valid    <= w_src2_valid;
            r_onzcv_valid   <= w_nzcv_valid;
            r_src1_tag      <= w_src1_tag;
            r_src2_tag      <= w_src2_tag;
            r_onzcv_tag     <= w_nzcv_tag;
            r_src1_value    <= w_src1_value;
            r_src2_value    <= w_src2_value;
            r_onzcv         <= w_nzcv_value;
            r_out_dst       <= in_d_dst;
            r_out_dst_tag   <= in_rob_next_index;
            r_out_set_nzcv  <= in_d_set_nzcv;
            r_out_uses_nzcv <= in_d_uses_nzcv;
         end
      end else begin
         // Stalled: only waiting operands may change, and only on a tag hit.
         if (!r_src1_valid && w_wk1_hit) begin
            r_src1_valid <= 1'b1;
            r_src1_tag   <= '0;
            r_src1_value <= w_wk1_value;
         end
         if (!r_src2_valid && w_wk2_hit) begin
            r_src2_valid <= 1'b1;
            r_src2_tag   <= '0;
            r_src2_value <= w_wk2_value;
         end
         if (!r_onzcv_valid && w_wkn_hit) begin
            r_onzcv_valid <= 1'b1;
            r_onzcv_tag   <= '0;
            r_onzcv       <= w_wkn_value;
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_src1_valid = r_src1_valid;
   assign out_src2_valid = r_src2_valid;
   assign out_nzcv_valid = r_onzcv_valid;
   assign out_src1_tag   = r_src1_tag;
   assign out_src2_tag   = r_src2_tag;
   assign out_nzcv_tag   = r_onzcv_tag;
   assign out_src1_value = r_src1_value;
   assign out_src2_value = r_src2_value;
   assign out_nzcv       = r_onzcv;
   assign out_dst        = r_out_dst;
   assign out_dst_tag    = r_out_dst_tag;
   assign out_set_nzcv   = r_out_set_nzcv;
   assign out_uses_nzcv  = r_out_uses_nzcv;

endmodule

// File: tb/tb_rename_regfile.sv
// ---------------------------------------------------------------------------
// tb_rename_regfile
// Scoreboarded bench: the driver applies one stimulus per cycle, updates a
// behavioural register/rename model and pushes expected bundles; a monitor
// pops and compares whenever the output stage transfers.
// ---------------------------------------------------------------------------
module tb_rename_regfile;

   typedef struct packed {
      logic dv; logic [4:0] s1; logic [4:0] s2; logic [4:0] dst;
      logic we; logic setn; logic usen; logic useimm; logic [63:0] imm; logic [3:0] rob;
      logic [1:0] cv; logic [9:0] creg; logic [7:0] ctag; logic [127:0] cval;
      logic [1:0] cset; logic [7:0] cnz; logic flush; logic rdy;
   } stim_t;

   typedef struct packed {
      logic v1; logic [3:0] t1; logic [63:0] x1;
      logic v2; logic [3:0] t2; logic [63:0] x2;
      logic nv; logic [3:0] nt; logic [3:0] nz;
      logic [4:0] dst; logic [3:0] dtag; logic setn; logic usen;
   } exp_t;

   // ---------------- DUT signals ----------------
   logic in_clk = 1'b0;
   logic in_rst_n;
   logic in_d_valid, out_d_ready;
   logic [4:0] in_d_src1, in_d_src2, in_d_dst;
   logic in_d_dst_we, in_d_set_nzcv, in_d_uses_nzcv, in_d_use_imm;
   logic [63:0] in_d_imm;
   logic [3:0] in_rob_next_index;
   logic [1:0] in_c_valid;
   logic [9:0] in_c_reg;
   logic [7:0] in_c_tag;
   logic [127:0] in_c_value;
   logic [1:0] in_c_set_nzcv;
   logic [7:0] in_c_nzcv;
   logic in_flush, out_valid, in_ready;
   logic out_src1_valid, out_src2_valid, out_nzcv_valid;
   logic [3:0] out_src1_tag, out_src2_tag, out_nzcv_tag;
   logic [63:0] out_src1_value, out_src2_value;
   logic [3:0] out_nzcv;
   logic [4:0] out_dst;
   logic [3:0] out_dst_tag;
   logic out_set_nzcv, out_uses_nzcv;

   rename_regfile dut (
      .in_clk(in_clk), .in_rst_n(in_rst_n),
      .in_d_valid(in_d_valid), .out_d_ready(out_d_ready),
      .in_d_src1(in_d_src1), .in_d_src2(in_d_src2), .in_d_dst(in_d_dst),
      .in_d_dst_we(in_d_dst_we), .in_d_set_nzcv(in_d_set_nzcv),
      .in_d_uses_nzcv(in_d_uses_nzcv), .in_d_use_imm(in_d_use_imm),
      .in_d_imm(in_d_imm), .in_rob_next_index(in_rob_next_index),
      .in_c_valid(in_c_valid), .in_c_reg(in_c_reg), .in_c_tag(in_c_tag),
      .in_c_value(in_c_value), .in_c_set_nzcv(in_c_set_nzcv), .in_c_nzcv(in_c_nzcv),
      .in_flush(in_flush), .out_valid(out_valid), .in_ready(in_ready),
      .out_src1_valid(out_src1_valid), .out_src2_valid(out_src2_valid),
      .out_nzcv_valid(out_nzcv_valid), .out_src1_tag(out_src1_tag),
      .out_src2_tag(out_src2_tag), .out_nzcv_tag(out_nzcv_tag),
      .out_src1_value(out_src1_value), .out_src2_value(out_src2_value),
      .out_nzcv(out_nzcv), .out_dst(out_dst), .out_dst_tag(out_dst_tag),
      .out_set_nzcv(out_set_nzcv), .out_uses_nzcv(out_uses_nzcv)
   );

   // ---------------- clock ----------------
   always #5 in_clk = ~in_clk;

   // ---------------- reference model state ----------------
   logic [63:0] m_arch [32];
   bit          m_pend [32];
   logic [3:0]  m_tag  [32];
   logic [3:0]  m_nzcv;
   bit          m_npend;
   logic [3:0]  m_ntag;
   exp_t        exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_init();
      for (int i = 0; i < 32; i++) begin
         m_arch[i] = '0; m_pend[i] = 0; m_tag[i] = '0;
      end
      m_nzcv = '0; m_npend = 0; m_ntag = '0;
      exp_q.delete();
   endtask

   function automatic stim_t nop();
      stim_t s = '0;
      s.rdy = 1'b1;
      return s;
   endfunction

   // Source lookup following the architectural rules: immediate, x31 = 0,
   // committed value, same-cycle commit carrying the awaited tag, else wait.
   function automatic void resolve(input stim_t s, input logic useimm, input logic [4:0] src,
                                   output logic v, output logic [3:0] t, output logic [63:0] x);
      v = 1'b1; t = '0; x = '0;
      if (useimm) x = s.imm;
      else if (src == 5'd31) x = '0;
      else if (!m_pend[src]) x = m_arch[src];
      else begin
         v = 1'b0; t = m_tag[src];
         for (int p = 0; p < 2; p++)
            if (s.cv[p] && s.ctag[p*4 +: 4] == m_tag[src]) begin
               v = 1'b1; t = '0; x = s.cval[p*64 +: 64];
            end
      end
   endfunction

   // One cycle: inputs applied just after a rising edge, model advanced to
   // the state expected after the next rising edge.
   task automatic step(input stim_t s);
      exp_t e, h;
      bit ready, acc;
      chk("out_valid", out_valid, exp_q.size() != 0);
      in_d_valid = s.dv; in_d_src1 = s.s1; in_d_src2 = s.s2; in_d_dst = s.dst;
      in_d_dst_we = s.we; in_d_set_nzcv = s.setn; in_d_uses_nzcv = s.usen;
      in_d_use_imm = s.useimm; in_d_imm = s.imm; in_rob_next_index = s.rob;
      in_c_valid = s.cv; in_c_reg = s.creg; in_c_tag = s.ctag; in_c_value = s.cval;
      in_c_set_nzcv = s.cset; in_c_nzcv = s.cnz; in_flush = s.flush; in_ready = s.rdy;
      #1;
      ready = !s.flush && (exp_q.size() == 0 || s.rdy);
      chk("d_ready", out_d_ready, ready);
      acc = s.dv && ready;
      // held bundle: discarded by a flush, else woken by matching commits
      if (exp_q.size() != 0 && !s.rdy) begin
         if (s.flush) void'(exp_q.pop_front());
         else begin
            h = exp_q[0]; e = h;
            for (int p = 0; p < 2; p++) begin
               if (s.cv[p] && !h.v1 && s.ctag[p*4 +: 4] == h.t1) begin
                  e.v1 = 1'b1; e.t1 = '0; e.x1 = s.cval[p*64 +: 64];
               end
               if (s.cv[p] && !h.v2 && s.ctag[p*4 +: 4] == h.t2) begin
                  e.v2 = 1'b1; e.t2 = '0; e.x2 = s.cval[p*64 +: 64];
               end
               if (s.cv[p] && s.cset[p] && !h.nv && s.ctag[p*4 +: 4] == h.nt) begin
                  e.nv = 1'b1; e.nt = '0; e.nz = s.cnz[p*4 +: 4];
               end
            end
            exp_q[0] = e;
         end
      end
      if (acc) begin
         e = '0;
         resolve(s, 1'b0, s.s1, e.v1, e.t1, e.x1);
         resolve(s, s.useimm, s.s2, e.v2, e.t2, e.x2);
         e.nv = 1'b1; e.nt = '0; e.nz = m_nzcv;
         if (m_npend) begin
            e.nv = 1'b0; e.nt = m_ntag; e.nz = '0;
            for (int p = 0; p < 2; p++)
               if (s.cv[p] && s.cset[p] && s.ctag[p*4 +: 4] == m_ntag) begin
                  e.nv = 1'b1; e.nt = '0; e.nz = s.cnz[p*4 +: 4];
               end
         end
         e.dst = s.dst; e.dtag = s.rob; e.setn = s.setn; e.usen = s.usen;
         exp_q.push_back(e);
      end
      // architectural update: commits in port order, then rename, then flush
      for (int p = 0; p < 2; p++) begin
         if (s.cv[p] && s.creg[p*5 +: 5] != 5'd31) begin
            m_arch[s.creg[p*5 +: 5]] = s.cval[p*64 +: 64];
            if (m_tag[s.creg[p*5 +: 5]] == s.ctag[p*4 +: 4]) m_pend[s.creg[p*5 +: 5]] = 0;
         end
         if (s.cv[p] && s.cset[p]) begin
            m_nzcv = s.cnz[p*4 +: 4];
            if (m_ntag == s.ctag[p*4 +: 4]) m_npend = 0;
         end
      end
      if (acc && s.we && s.dst != 5'd31) begin
         m_pend[s.dst] = 1; m_tag[s.dst] = s.rob;
      end
      if (acc && s.setn) begin
         m_npend = 1; m_ntag = s.rob;
      end
      if (s.flush) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 0;
         m_npend = 0;
      end
      @(posedge in_clk);
      #1;
   endtask

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 7) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   function automatic stim_t rand_stim(input logic [3:0] rob);
      stim_t s = nop();
      logic [4:0] r;
      s.dv = ($urandom_range(0, 9) < 7);
      s.s1 = pick_reg(); s.s2 = pick_reg(); s.dst = pick_reg();
      s.we = 1'($urandom_range(0, 1)); s.setn = ($urandom_range(0, 3) == 0);
      s.usen = 1'($urandom_range(0, 1)); s.useimm = ($urandom_range(0, 3) == 0);
      s.imm = {$urandom, $urandom}; s.rob = rob;
      for (int p = 0; p < 2; p++) begin
         if ($urandom_range(0, 9) < 4) begin
            r = pick_reg();
            s.cv[p] = 1'b1;
            s.creg[p*5 +: 5] = r;
            s.ctag[p*4 +: 4] = (m_pend[r] && $urandom_range(0, 3) != 0) ? m_tag[r] : 4'($urandom_range(0, 15));
            s.cval[p*64 +: 64] = {$urandom, $urandom};
            s.cset[p] = ($urandom_range(0, 3) == 0);
            if (s.cset[p] && m_npend && $urandom_range(0, 1) == 1) s.ctag[p*4 +: 4] = m_ntag;
            s.cnz[p*4 +: 4] = 4'($urandom_range(0, 15));
         end
      end
      s.flush = ($urandom_range(0, 39) == 0);
      s.rdy = ($urandom_range(0, 9) < 7);
      return s;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge in_clk);
         if (in_rst_n && out_valid && in_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_bundle actual=out_valid expected=no_bundle dst=%0d", out_dst);
            end else begin
               e = exp_q.pop_front();
               chk("src1_valid", out_src1_valid, e.v1);
               chk("src1_tag",   out_src1_tag,   e.t1);
               chk("src1_value", out_src1_value, e.x1);
               chk("src2_valid", out_src2_valid, e.v2);
               chk("src2_tag",   out_src2_tag,   e.t2);
               chk("src2_value", out_src2_value, e.x2);
               chk("nzcv_valid", out_nzcv_valid, e.nv);
               chk("nzcv_tag",   out_nzcv_tag,   e.nt);
               chk("nzcv",       out_nzcv,       e.nz);
               chk("dst",        out_dst,        e.dst);
               chk("dst_tag",    out_dst_tag,    e.dtag);
               chk("set_nzcv",   out_set_nzcv,   e.setn);
               chk("uses_nzcv",  out_uses_nzcv,  e.usen);
            end
         end
      end
   end

   // ---------------- driver ----------------
   initial begin
      stim_t s;
      logic [3:0] rob;
      model_init();
      s = nop();
      in_rst_n = 1'b0;
      in_d_valid = 0; in_d_src1 = 0; in_d_src2 = 0; in_d_dst = 0; in_d_dst_we = 0;
      in_d_set_nzcv = 0; in_d_uses_nzcv = 0; in_d_use_imm = 0; in_d_imm = 0;
      in_rob_next_index = 0; in_c_valid = 0; in_c_reg = 0; in_c_tag = 0; in_c_value = 0;
      in_c_set_nzcv = 0; in_c_nzcv = 0; in_flush = 0; in_ready = 1;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_src1_valid", out_src1_valid, 0);
      chk("rst_nzcv_valid", out_nzcv_valid, 0);
      chk("rst_src2_value", out_src2_value, 0);
      chk("rst_dst_tag", out_dst_tag, 0);
      repeat (2) @(posedge in_clk);
      #1 in_rst_n = 1'b1;
      #1 chk("rst_d_ready", out_d_ready, 1);

      // rename then read of the renamed register
      s = nop(); s.dv = 1; s.s1 = 1; s.s2 = 2; s.dst = 3; s.we = 1; s.rob = 5; step(s);
      step(nop());
      s = nop(); s.dv = 1; s.s1 = 3; s.rob = 6; step(s);
      chk("t1_src1_valid", out_src1_valid, 0);
      chk("t1_src1_tag", out_src1_tag, 5);

      // commit bypass into same-cycle dispatch, then architectural read
      s = nop(); s.dv = 1; s.s1 = 3; s.rob = 7;
      s.cv = 2'b01; s.creg[4:0] = 3; s.ctag[3:0] = 5; s.cval[63:0] = 64'd42; step(s);
      chk("t2_bypass_valid", out_src1_valid, 1);
      chk("t2_bypass_value", out_src1_value, 42);
      s = nop(); s.dv = 1; s.s1 = 3; s.rob = 8; step(s);
      chk("t2_arch_valid", out_src1_valid, 1);
      chk("t2_arch_value", out_src1_value, 42);

      // src == dst sees the old mapping
      s = nop(); s.cv = 2'b01; s.creg[4:0] = 4; s.ctag[3:0] = 0; s.cval[63:0] = 64'd9; step(s);
      s = nop(); s.dv = 1; s.s1 = 4; s.dst = 4; s.we = 1; s.rob = 7; step(s);
      chk("t3_old_valid", out_src1_valid, 1);
      chk("t3_old_value", out_src1_value, 9);
      s = nop(); s.dv = 1; s.s2 = 4; s.rob = 8; step(s);
      chk("t3_new_valid", out_src2_valid, 0);
      chk("t3_new_tag", out_src2_tag, 7);

      // zero register
      s = nop(); s.dv = 1; s.s2 = 31; s.rob = 9; step(s);
      chk("t4_zero_valid", out_src2_valid, 1);
      chk("t4_zero_value", out_src2_value, 0);
      s = nop(); s.dv = 1; s.dst = 31; s.we = 1; s.rob = 10; step(s);
      s = nop(); s.dv = 1; s.s1 = 31; s.rob = 11; step(s);
      chk("t4_never_pending", out_src1_valid, 1);

      // wake-up of a stalled operand
      s = nop(); s.dv = 1; s.dst = 2; s.we = 1; s.rob = 2; step(s);
      s = nop(); s.dv = 1; s.s2 = 2; s.rob = 12; step(s);
      chk("t5_wait_valid", out_src2_valid, 0);
      chk("t5_wait_tag", out_src2_tag, 2);
      s = nop(); s.rdy = 0; step(s);
      s = nop(); s.rdy = 0; s.cv = 2'b10; s.creg[9:5] = 2; s.ctag[7:4] = 2; s.cval[127:64] = 64'h55; step(s);
      chk("t5_wake_held", out_valid, 1);
      chk("t5_wake_valid", out_src2_valid, 1);
      chk("t5_wake_value", out_src2_value, 64'h55);
      step(nop());

      // flush recovery
      s = nop(); s.dv = 1; s.dst = 1; s.we = 1; s.setn = 1; s.rob = 3; step(s);
      s = nop(); s.flush = 1; s.dv = 1; s.s1 = 1; s.rob = 4; step(s);
      chk("t6_flush_valid", out_valid, 0);
      s = nop(); s.dv = 1; s.s1 = 1; s.usen = 1; s.rob = 13; step(s);
      chk("t6_x1_valid", out_src1_valid, 1);
      chk("t6_x1_value", out_src1_value, 0);
      chk("t6_nzcv_valid", out_nzcv_valid, 1);

      // reset while a bundle is held
      s = nop(); s.dv = 1; s.s1 = 5; s.rob = 14; step(s);
      s = nop(); s.rdy = 0; step(s);
      #2 in_rst_n = 1'b0;
      #1;
      chk("rst_stall_valid", out_valid, 0);
      chk("rst_stall_dst_tag", out_dst_tag, 0);
      model_init();
      @(posedge in_clk);
      #1 in_rst_n = 1'b1;

      // randomized traffic
      rob = '0;
      for (int i = 0; i < 3000; i++) begin
         step(rand_stim(rob));
         rob = rob + 4'd1;
      end
      repeat (3) step(nop());
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
